// File: rtl/flash_readback_uart_tx.sv
// flash_readback_uart_tx
//
// Readback path of the flash programmer. It pulls 64-bit words out of the
// spi_phy fetch FIFO and sends them byte by byte through uart_tx, so the
// host can compare them with what it wrote. This is the mirror image of the
// write path, which packs UART bytes into 64-bit words.
//
// Parameters:
//   FETCH_LATENCY  cycles from the fetch_out pulse until fetch_din is valid (1..3)
//   MSB_FIRST      1: send word[63:56] first, 0: send word[7:0] first
//
// Ports:
//   clk             system clock (CFGMCLK domain)
//   rst             synchronous active-high reset
//   start           one-cycle job request, only honoured while idle
//   byte_num        number of bytes in the job, sampled with start
//   done            one-cycle pulse once the last byte has left uart_tx
//   busy            high from an accepted start until done
//   tx_cnt          bytes completed in the current job
//   fetch_din       word from the fetch FIFO
//   fetch_out       one-cycle FIFO read strobe
//   fetch_empty_in  fetch FIFO empty flag
//   o_Tx_DV         one-cycle byte-valid pulse to uart_tx
//   o_Tx_Byte       byte to uart_tx, held until the next o_Tx_DV
//   i_Tx_Active     uart_tx is shifting a byte
//   i_Tx_Done       uart_tx byte complete pulse
module flash_readback_uart_tx #(
    parameter int FETCH_LATENCY = 1,
    parameter bit MSB_FIRST     = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] byte_num,
    output logic        done,
    output logic        busy,
    output logic [31:0] tx_cnt,
    input  logic [63:0] fetch_din,
    output logic        fetch_out,
    input  logic        fetch_empty_in,
    output logic        o_Tx_DV,
    output logic [7:0]  o_Tx_Byte,
    input  logic        i_Tx_Active,
    input  logic        i_Tx_Done
);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT_DATA,
        LOAD,
        WAIT_DONE
    } state_t;

    localparam logic [1:0] LAT = 2'(FETCH_LATENCY);

    state_t      state;
    logic [31:0] remaining;
    logic [63:0] word;
    logic [2:0]  idx;
    logic [1:0]  lat_cnt;
    logic [7:0]  sel_byte;

    // Byte picked out of the captured word for the current index.
    always_comb begin
        sel_byte = 8'h00;
        if (MSB_FIRST) begin
            sel_byte = word[{3'd7 - idx, 3'b000} +: 8];
        end else begin
            sel_byte = word[{idx, 3'b000} +: 8];
        end
    end

    // Job sequencer. done, fetch_out and o_Tx_DV default low every cycle so
    // each of them is a single-cycle pulse. remaining counts down the bytes
    // still to be acknowledged; a partial last word simply ends the job
    // before idx reaches 7, which discards its trailing bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            done      <= 1'b0;
            busy      <= 1'b0;
            tx_cnt    <= 32'd0;
            fetch_out <= 1'b0;
            o_Tx_DV   <= 1'b0;
            o_Tx_Byte <= 8'h00;
            remaining <= 32'd0;
            word      <= 64'd0;
            idx       <= 3'd0;
            lat_cnt   <= 2'd0;
        end else begin
            done      <= 1'b0;
            fetch_out <= 1'b0;
            o_Tx_DV   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (byte_num == 32'd0) begin
                            done <= 1'b1;
                        end else begin
                            remaining <= byte_num;
                            tx_cnt    <= 32'd0;
                            busy      <= 1'b1;
                            state     <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (!fetch_empty_in) begin
                        fetch_out <= 1'b1;
                        lat_cnt   <= 2'd0;
                        state     <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    // lat_cnt is 0 in the cycle fetch_out is high, so the
                    // word is taken in the cycle it first becomes valid.
                    if (lat_cnt == LAT) begin
                        word  <= fetch_din;
                        idx   <= 3'd0;
                        state <= LOAD;
                    end else begin
                        lat_cnt <= lat_cnt + 2'd1;
                    end
                end
                LOAD: begin
                    if (!i_Tx_Active) begin
                        o_Tx_Byte <= sel_byte;
                        o_Tx_DV   <= 1'b1;
                        state     <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (i_Tx_Done) begin
                        tx_cnt    <= tx_cnt + 32'd1;
                        remaining <= remaining - 32'd1;
                        if (remaining == 32'd1) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else if (idx == 3'd7) begin
                            state <= FETCH;
                        end else begin
                            idx   <= idx + 3'd1;
                            state <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_readback_uart_tx.sv
// tb_flash_readback_uart_tx
//
// Runs two instances side by side on the same jobs: lane 0 is MSB-first with
// a one-cycle fetch latency, lane 1 is LSB-first with a three-cycle latency.
// Each lane has its own fetch FIFO model (shared word store, own read
// pointer) and its own uart_tx model. Sent bytes are logged and compared
// with the bytes expected from the FIFO contents and the byte order rule.
module tb_flash_readback_uart_tx;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] byte_num = 32'd0;
    logic        stall = 1'b0;

    logic [1:0]  done_s;
    logic [1:0]  busy_s;
    logic [31:0] tx_cnt_s [2];
    logic [63:0] fetch_din_s [2];
    logic [1:0]  fetch_out_s;
    logic [1:0]  fetch_empty_s;
    logic [1:0]  tx_dv_s;
    logic [7:0]  tx_byte_s [2];
    logic [1:0]  tx_active_s = 2'b00;
    logic [1:0]  tx_done_s = 2'b00;

    // FIFO model: words live in mem, pushed by the stimulus, popped per lane.
    logic [63:0] mem [256];
    int          pushed = 0;
    int          popped [2] = '{0, 0};
    logic [63:0] pend [2];
    int          dly [2] = '{0, 0};

    // uart_tx model state
    int          bit_time = 3;
    int          left [2] = '{0, 0};

    // Monitor logs
    logic [7:0]  rx_mem [2][1024];
    int          rx_n [2] = '{0, 0};
    int          fetch_cnt [2] = '{0, 0};
    int          done_cnt [2] = '{0, 0};
    int          done_tx [2] = '{0, 0};
    int          since_done [2] = '{100, 100};

    // Per-job snapshots
    int          job_base [2];
    int          job_f0 [2];
    int          job_r0 [2];
    int          job_d0 [2];

    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    flash_readback_uart_tx #(.FETCH_LATENCY(LAT0), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .start(start), .byte_num(byte_num),
        .done(done_s[0]), .busy(busy_s[0]), .tx_cnt(tx_cnt_s[0]),
        .fetch_din(fetch_din_s[0]), .fetch_out(fetch_out_s[0]),
        .fetch_empty_in(fetch_empty_s[0]),
        .o_Tx_DV(tx_dv_s[0]), .o_Tx_Byte(tx_byte_s[0]),
        .i_Tx_Active(tx_active_s[0]), .i_Tx_Done(tx_done_s[0])
    );

    flash_readback_uart_tx #(.FETCH_LATENCY(LAT1), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .start(start), .byte_num(byte_num),
        .done(done_s[1]), .busy(busy_s[1]), .tx_cnt(tx_cnt_s[1]),
        .fetch_din(fetch_din_s[1]), .fetch_out(fetch_out_s[1]),
        .fetch_empty_in(fetch_empty_s[1]),
        .o_Tx_DV(tx_dv_s[1]), .o_Tx_Byte(tx_byte_s[1]),
        .i_Tx_Active(tx_active_s[1]), .i_Tx_Done(tx_done_s[1])
    );

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Empty flag: forced by the stall control or no unread words for the lane.
    always_comb begin
        for (int g = 0; g < 2; g++) begin
            fetch_empty_s[g] = stall || (popped[g] >= pushed);
        end
    end

    // FIFO read data and uart_tx behaviour for both lanes. Before a fetched
    // word becomes valid the data bus carries junk, so an early capture shows.
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (fetch_out_s[g]) begin
                if ((g == 0 ? LAT0 : LAT1) == 1) begin
                    fetch_din_s[g] <= mem[popped[g] % 256];
                end else begin
                    pend[g]        <= mem[popped[g] % 256];
                    dly[g]         <= (g == 0 ? LAT0 : LAT1) - 1;
                    fetch_din_s[g] <= {$urandom, $urandom};
                end
                popped[g] <= popped[g] + 1;
            end else if (dly[g] > 0) begin
                dly[g] <= dly[g] - 1;
                if (dly[g] == 1) fetch_din_s[g] <= pend[g];
            end

            tx_done_s[g] <= 1'b0;
            if (tx_active_s[g]) begin
                if (left[g] <= 1) begin
                    tx_active_s[g] <= 1'b0;
                    tx_done_s[g]   <= 1'b1;
                end else begin
                    left[g] <= left[g] - 1;
                end
            end
            if (tx_dv_s[g] && !tx_active_s[g]) begin
                tx_active_s[g] <= 1'b1;
                left[g]        <= bit_time;
            end
        end
    end

    // Protocol monitor, sampled mid-cycle.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (tx_done_s[g]) since_done[g] = 0;
            else if (since_done[g] < 100) since_done[g]++;
            if (fetch_out_s[g]) begin
                checkOutput($sformatf("fetch_when_empty%0d", g), 64'(fetch_empty_s[g]), 64'd0);
                fetch_cnt[g]++;
            end
            if (tx_dv_s[g]) begin
                checkOutput($sformatf("dv_while_active%0d", g), 64'(tx_active_s[g]), 64'd0);
                checkOutput($sformatf("dv_gap_after_done%0d", g), 64'(since_done[g] >= 1), 64'd1);
                rx_mem[g][rx_n[g] % 1024] = tx_byte_s[g];
                rx_n[g]++;
            end
            if (done_s[g]) begin
                done_cnt[g]++;
                done_tx[g] = int'(tx_cnt_s[g]);
                checkOutput($sformatf("busy_at_done%0d", g), 64'(busy_s[g]), 64'd0);
            end
        end
    end

    // Expected k-th byte of a job whose first word is mem[base].
    function automatic logic [7:0] refByte(input int g, input int base, input int k);
        logic [63:0] w;
        int pos;
        w   = mem[(base + k / 8) % 256];
        pos = k % 8;
        if (g == 0) return 8'(w >> (56 - 8 * pos));
        return 8'(w >> (8 * pos));
    endfunction

    task automatic pushWord(input logic [63:0] w);
        mem[pushed % 256] = w;
        pushed++;
    endtask

    task automatic checkIdle(input string tag);
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("%s_done%0d", tag, g), 64'(done_s[g]), 64'd0);
            checkOutput($sformatf("%s_busy%0d", tag, g), 64'(busy_s[g]), 64'd0);
            checkOutput($sformatf("%s_tx_cnt%0d", tag, g), 64'(tx_cnt_s[g]), 64'd0);
            checkOutput($sformatf("%s_fetch_out%0d", tag, g), 64'(fetch_out_s[g]), 64'd0);
            checkOutput($sformatf("%s_dv%0d", tag, g), 64'(tx_dv_s[g]), 64'd0);
            checkOutput($sformatf("%s_byte%0d", tag, g), 64'(tx_byte_s[g]), 64'd0);
        end
    endtask

    task automatic startJob(input int n);
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            job_base[g] = popped[g];
            job_f0[g]   = fetch_cnt[g];
            job_r0[g]   = rx_n[g];
            job_d0[g]   = done_cnt[g];
        end
        byte_num = 32'(n);
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic awaitDone(input int budget);
        int b;
        b = budget;
        while (!(done_cnt[0] > job_d0[0] && done_cnt[1] > job_d0[1]) && b > 0) begin
            @(negedge clk);
            b--;
        end
        checkOutput("job_done_in_time", 64'(b > 0), 64'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic verifyJob(input int n);
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("done_pulses%0d", g), 64'(done_cnt[g] - job_d0[g]), 64'd1);
            checkOutput($sformatf("tx_cnt_at_done%0d", g), 64'(done_tx[g]), 64'(n));
            checkOutput($sformatf("bytes_sent%0d", g), 64'(rx_n[g] - job_r0[g]), 64'(n));
            checkOutput($sformatf("fifo_reads%0d", g), 64'(fetch_cnt[g] - job_f0[g]), 64'((n + 7) / 8));
            checkOutput($sformatf("busy_after%0d", g), 64'(busy_s[g]), 64'd0);
            for (int k = 0; k < n; k++) begin
                checkOutput($sformatf("byte%0d_lane%0d", k, g),
                            64'(rx_mem[g][(job_r0[g] + k) % 1024]),
                            64'(refByte(g, job_base[g], k)));
            end
        end
    endtask

    task automatic applyStimulus(input int n);
        startJob(n);
        awaitDone(n * (bit_time + 8) + 100);
        verifyJob(n);
    endtask

    task automatic waitUartIdle();
        int b;
        b = 10000;
        while (tx_active_s != 2'b00 && b > 0) begin
            @(negedge clk);
            b--;
        end
        checkOutput("uart_idle_in_time", 64'(b > 0), 64'd1);
    endtask

    initial begin
        #800000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        int b;
        int f0 [2];
        int r0 [2];

        repeat (3) @(negedge clk);
        checkIdle("reset");
        rst = 1'b0;

        $display("[TB] byte order, full word");
        pushWord(64'h0011223344556677);
        applyStimulus(8);

        $display("[TB] partial last word");
        pushWord(64'h0706050403020100);
        pushWord(64'h0F0E0D0C0B0A0908);
        applyStimulus(11);

        $display("[TB] zero length");
        for (int g = 0; g < 2; g++) begin
            f0[g] = fetch_cnt[g];
            r0[g] = rx_n[g];
            job_d0[g] = done_cnt[g];
        end
        @(negedge clk);
        byte_num = 32'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("zero_done%0d", g), 64'(done_s[g]), 64'd1);
            checkOutput($sformatf("zero_busy%0d", g), 64'(busy_s[g]), 64'd0);
        end
        repeat (10) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("zero_done_pulses%0d", g), 64'(done_cnt[g] - job_d0[g]), 64'd1);
            checkOutput($sformatf("zero_fetch%0d", g), 64'(fetch_cnt[g] - f0[g]), 64'd0);
            checkOutput($sformatf("zero_bytes%0d", g), 64'(rx_n[g] - r0[g]), 64'd0);
        end

        $display("[TB] empty stall");
        pushWord({$urandom, $urandom});
        stall = 1'b1;
        startJob(8);
        repeat (500) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("stall_fetch%0d", g), 64'(fetch_cnt[g] - job_f0[g]), 64'd0);
            checkOutput($sformatf("stall_bytes%0d", g), 64'(rx_n[g] - job_r0[g]), 64'd0);
            checkOutput($sformatf("stall_busy%0d", g), 64'(busy_s[g]), 64'd1);
        end
        stall = 1'b0;
        @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("fetch_after_stall%0d", g), 64'(fetch_out_s[g]), 64'd1);
        end
        awaitDone(8 * (bit_time + 8) + 100);
        verifyJob(8);

        $display("[TB] slow uart handshake");
        bit_time = 4340;
        pushWord({$urandom, $urandom});
        startJob(3);
        b = 10000;
        while ((rx_n[0] - job_r0[0]) < 1 && b > 0) begin
            @(negedge clk);
            b--;
        end
        repeat (100) @(negedge clk);
        byte_num = 32'd20;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        awaitDone(3 * (4340 + 10) + 200);
        verifyJob(3);

        $display("[TB] random jobs");
        for (int j = 0; j < 6; j++) begin
            n        = $urandom_range(1, 30);
            bit_time = $urandom_range(1, 12);
            for (int w = 0; w < (n + 7) / 8; w++) pushWord({$urandom, $urandom});
            applyStimulus(n);
        end

        $display("[TB] reset mid-job");
        bit_time = 6;
        pushWord({$urandom, $urandom});
        pushWord({$urandom, $urandom});
        startJob(16);
        b = 2000;
        while (!(tx_cnt_s[0] >= 32'd3 && tx_cnt_s[1] >= 32'd3) && b > 0) begin
            @(negedge clk);
            b--;
        end
        checkOutput("reached_three_bytes", 64'(b > 0), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        checkIdle("mid_reset");
        rst = 1'b0;
        for (int g = 0; g < 2; g++) job_d0[g] = done_cnt[g];
        repeat (30) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checkOutput($sformatf("no_done_after_reset%0d", g), 64'(done_cnt[g] - job_d0[g]), 64'd0);
            checkOutput($sformatf("tx_cnt_after_reset%0d", g), 64'(tx_cnt_s[g]), 64'd0);
        end
        waitUartIdle();
        applyStimulus(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
